neopix_tx: RTL and testbench
============================

NEOPIX_TX -- requirements
Module: neopix_tx

Interface
REQ-001 Parameter NUM_LEDS, default 8, maximum pixels per frame.
REQ-002 Parameter SYSTEM_CLOCK, default 50_000_000, clk_i frequency in Hz.
REQ-003 Parameter BYTES_PER_LED, default 3, legal values 3 (RGB) or 4 (RGBW); any other value SHALL be a elaboration error.
REQ-004 Parameter RESET_US, default 80, latch low time in microseconds.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 reset_i  in  1  asynchronous, active-high reset.
REQ-007 start_i  in  1  frame request; rising edge is the event.
REQ-008 mode_i  in  1  timing mode: 0 WS2812B, 1 SK6812; sampled at frame start.
REQ-009 led_count_i  in  $clog2(NUM_LEDS+1)  pixels in frame; sampled at frame start.
REQ-010 pix_ready_o  out  1  block can accept a pixel.
REQ-011 pix_valid_i  in  1  pixel data valid; transfer when pix_valid_i and pix_ready_o are both high.
REQ-012 pix_data_i  in  32  {W,R,G,B}; W ignored when BYTES_PER_LED=3.
REQ-013 addr_o  out  $clog2(NUM_LEDS)  index of the pixel currently requested.
REQ-014 busy_o  out  1  frame in progress, including trailing latch.
REQ-015 done_o  out  1  one-cycle pulse at frame completion.
REQ-016 underrun_o  out  1  sticky: data missing at a pixel boundary.
REQ-017 clr_i  in  1  synchronous clear of underrun_o.
REQ-018 do_o  out  1  serial output to LED chain.

Function
REQ-019 Bit period T = SYSTEM_CLOCK/800_000 cycles (integer division); high times: mode 0 T0H=floor(0.32*T), T1H=floor(0.64*T); mode 1 T0H=floor(0.25*T), T1H=floor(0.50*T).
REQ-020 Each bit: do_o high for T0H or T1H cycles, then low for the rest of T; consecutive bits abut with no gap cycles.
REQ-021 Byte order on wire: G, R, B, then W if BYTES_PER_LED=4; MSB first per byte.
REQ-022 Latch count L = SYSTEM_CLOCK/1_000_000*RESET_US cycles with do_o low.
REQ-023 States: LATCH (do_o low, counting L), IDLE, SHIFT, FLUSH; FLUSH is a LATCH entered after a frame.
REQ-024 After reset the block SHALL be in LATCH and SHALL NOT begin a frame until L cycles elapse.
REQ-025 A start_i rising edge seen in LATCH, FLUSH or SHIFT SHALL set a one-deep pending flag; further edges while pending SHALL be dropped.
REQ-026 In IDLE with pending set: clear pending, sample mode_i and led_count_i (values >NUM_LEDS clamp to NUM_LEDS), assert busy_o, set addr_o=0.
REQ-027 led_count sample of 0: go directly to FLUSH without driving any bit, done_o after L cycles.
REQ-028 One-pixel prefetch buffer: pix_ready_o high whenever buffer empty and pixels remain to request; addr_o increments on each transfer, holds after last.
REQ-029 First pixel: SHIFT starts the cycle after the first transfer; do_o rises that cycle.
REQ-030 At the end of each pixel's last bit, the buffered pixel SHALL load into the shift register with no gap; buffer then empties.
REQ-031 If the buffer is empty at that boundary and pixels remain: set underrun_o, abort frame, enter FLUSH (do_o low).
REQ-032 After the last pixel's last bit: enter FLUSH; after L cycles pulse done_o, drop busy_o, enter IDLE (or start next frame if pending).
REQ-033 busy_o SHALL be low only in IDLE and the initial post-reset LATCH.
REQ-034 clr_i clears underrun_o; simultaneous set and clear SHALL leave underrun_o set.

Reset
REQ-035 reset_i high SHALL immediately force do_o=0, pix_ready_o=0, busy_o=0, done_o=0, underrun_o=0, addr_o=0, pending cleared, state LATCH with counter 0.
REQ-036 Reset mid-frame SHALL abandon the frame; no partial bit SHALL resume after release.

Verification
REQ-037 50 MHz, mode 0, count 1, data 0x00FF0080, source always valid -> 24 bits, T=62, G=0x00 highs 19, R=0xFF highs 39, B=0x80 first high 39 rest 19; done_o 4000 cycles after last bit.
REQ-038 Mode 1, count 2, BYTES_PER_LED=4 -> 64 bits, highs 15/31, no gap between pixels, addr_o 0 then 1.
REQ-039 Count 3, valid withheld for pixel 2 -> underrun_o=1 after 48 bits, do_o low, done_o after 4000 cycles; clr_i clears it.
REQ-040 start_i pulses twice during frame -> exactly one additional frame follows the first FLUSH.
REQ-041 Count 0 -> no do_o high, done_o 4000 cycles after start; count 9 with NUM_LEDS=8 -> 8 pixels sent.
REQ-042 reset_i asserted mid-bit -> do_o low same cycle; next frame starts only after 4000 low cycles.

Source files
------------

// File: rtl/neopix_tx.sv
// WS2812B / SK6812 serial LED transmitter with a one-pixel prefetch buffer.
// Sends G,R,B(,W) MSB first, then holds the line low for the latch time.
module neopix_tx #(
  parameter int NUM_LEDS      = 8,
  parameter int SYSTEM_CLOCK  = 50_000_000,
  parameter int BYTES_PER_LED = 3,
  parameter int RESET_US      = 80
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          mode_i,
  input  logic [$clog2(NUM_LEDS+1)-1:0] led_count_i,
  output logic                          pix_ready_o,
  input  logic                          pix_valid_i,
  input  logic [31:0]                   pix_data_i,
  output logic [$clog2(NUM_LEDS)-1:0]   addr_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          underrun_o,
  input  logic                          clr_i,
  output logic                          do_o
);

  localparam int T  = SYSTEM_CLOCK / 800_000;
  localparam int L  = SYSTEM_CLOCK / 1_000_000 * RESET_US;
  localparam int NB = 8 * BYTES_PER_LED;
  localparam int TW = $clog2(T + 1);
  localparam int LW = $clog2(L + 1);
  localparam int BW = $clog2(NB + 1);
  localparam int CW = $clog2(NUM_LEDS + 1);
  localparam int AW = $clog2(NUM_LEDS);

  localparam logic [TW-1:0] T_LAST  = TW'(T - 1);
  localparam logic [TW-1:0] T0H_M0  = TW'(T * 32 / 100);
  localparam logic [TW-1:0] T1H_M0  = TW'(T * 64 / 100);
  localparam logic [TW-1:0] T0H_M1  = TW'(T * 25 / 100);
  localparam logic [TW-1:0] T1H_M1  = TW'(T * 50 / 100);
  localparam logic [LW-1:0] L_LAST  = LW'(L - 1);
  localparam logic [BW-1:0] NB_LAST = BW'(NB - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_LEDS);

  generate
    if (BYTES_PER_LED != 3 && BYTES_PER_LED != 4) begin : g_bad_bpl
      $error("neopix_tx: BYTES_PER_LED must be 3 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {LATCH, IDLE, SHIFT, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [TW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [31:0]     sh_q, sh_d;
  logic [31:0]     buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic [CW-1:0]   req_left_q, req_left_d;
  logic [CW-1:0]   pix_left_q, pix_left_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;
  logic            pending_q, pending_d;
  logic            start_prev_q;
  logic            do_q, do_d;

  logic            xfer;
  logic            launch;
  logic            ur_set;
  logic [CW-1:0]   cnt_clamp;

  // Wire order is G,R,B then W; the current bit is always sh_q[31].
  function automatic logic [31:0] wire_order(input logic [31:0] d);
    logic [7:0] w;
    w = (BYTES_PER_LED == 4) ? d[31:24] : 8'h00;
    return {d[15:8], d[23:16], d[7:0], w};
  endfunction

  function automatic logic [TW-1:0] hi_time(input logic m, input logic b);
    logic [TW-1:0] h;
    case ({m, b})
      2'b00:   h = T0H_M0;
      2'b01:   h = T1H_M0;
      2'b10:   h = T0H_M1;
      default: h = T1H_M1;
    endcase
    return h;
  endfunction

  assign cnt_clamp   = (led_count_i > CNT_MAX) ? CNT_MAX : led_count_i;
  assign pix_ready_o = (state_q == SHIFT || (state_q == IDLE && busy_q)) &&
                       !buf_full_q && (req_left_q != '0);
  assign xfer        = pix_ready_o & pix_valid_i;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    sh_d       = sh_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    req_left_d = req_left_q;
    pix_left_d = pix_left_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pending_d  = pending_q | (start_i & ~start_prev_q);
    launch     = 1'b0;
    ur_set     = 1'b0;

    if (xfer) begin
      buf_d      = pix_data_i;
      buf_full_d = 1'b1;
      req_left_d = req_left_q - 1'b1;
      if (req_left_q > CW'(1)) addr_d = addr_q + 1'b1;
    end

    case (state_q)
      LATCH, FLUSH: begin
        if (lat_cnt_q == L_LAST) begin
          lat_cnt_d = '0;
          state_d   = IDLE;
          if (state_q == FLUSH) begin
            done_d = 1'b1;
            busy_d = 1'b0;
            launch = pending_q;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (!busy_q) begin
          launch = pending_q;
        end else if (xfer) begin
          // First pixel bypasses the buffer so the line rises next cycle.
          sh_d       = wire_order(pix_data_i);
          buf_full_d = 1'b0;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          state_d    = SHIFT;
        end
      end
      default: begin
        if (bit_cnt_q == T_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q == NB_LAST) begin
            bit_idx_d = '0;
            if (pix_left_q == CW'(1)) begin
              state_d = FLUSH;
              lat_cnt_d = '0;
            end else if (buf_full_q) begin
              sh_d       = wire_order(buf_q);
              buf_full_d = 1'b0;
              pix_left_d = pix_left_q - 1'b1;
            end else if (xfer) begin
              sh_d       = wire_order(pix_data_i);
              buf_full_d = 1'b0;
              pix_left_d = pix_left_q - 1'b1;
            end else begin
              ur_set     = 1'b1;
              req_left_d = '0;
              state_d    = FLUSH;
              lat_cnt_d  = '0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            sh_d      = sh_q << 1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    endcase

    if (launch) begin
      pending_d  = 1'b0;
      mode_d     = mode_i;
      busy_d     = 1'b1;
      addr_d     = '0;
      buf_full_d = 1'b0;
      req_left_d = cnt_clamp;
      pix_left_d = cnt_clamp;
      lat_cnt_d  = '0;
      state_d    = (cnt_clamp == '0) ? FLUSH : IDLE;
    end

    underrun_d = (underrun_q & ~clr_i) | ur_set;
    do_d       = (state_d == SHIFT) && (bit_cnt_d < hi_time(mode_d, sh_d[31]));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= LATCH;
      lat_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      sh_q         <= '0;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      req_left_q   <= '0;
      pix_left_q   <= '0;
      addr_q       <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      pending_q    <= 1'b0;
      start_prev_q <= 1'b0;
      do_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      sh_q         <= sh_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      req_left_q   <= req_left_d;
      pix_left_q   <= pix_left_d;
      addr_q       <= addr_d;
      mode_q       <= mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      pending_q    <= pending_d;
      start_prev_q <= start_i;
      do_q         <= do_d;
    end
  end

  assign addr_o     = addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign underrun_o = underrun_q;
  assign do_o       = do_q;

endmodule

// File: tb/tb_neopix_tx.sv
// Directed bench for neopix_tx: RGB instance for most frames, RGBW instance
// for the SK6812 two-pixel frame. Waveform on do_o is decoded into high times.
module tb_neopix_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic [3:0]  cnt = 4'd1;
  logic        clr = 1'b0;

  logic        start3 = 1'b0, ready3, valid3, busy3, done3, ur3, do3;
  logic [31:0] data3;
  logic [2:0]  addr3;
  logic        start4 = 1'b0, ready4, valid4, busy4, done4, ur4, do4;
  logic [31:0] data4;
  logic [2:0]  addr4;

  logic [31:0] pix_tab [8];
  logic [3:0]  src_lim = 4'd8;
  localparam logic [31:0] P4_0 = 32'h11A5C33C;
  localparam logic [31:0] P4_1 = 32'h80FF0001;

  assign valid3 = ({1'b0, addr3} < src_lim);
  assign data3  = pix_tab[addr3];
  assign valid4 = 1'b1;
  assign data4  = (addr4 == 3'd0) ? P4_0 : P4_1;

  neopix_tx #(.BYTES_PER_LED(3)) u_dut3 (
    .clk_i(clk), .reset_i(rst), .start_i(start3), .mode_i(mode),
    .led_count_i(cnt), .pix_ready_o(ready3), .pix_valid_i(valid3),
    .pix_data_i(data3), .addr_o(addr3), .busy_o(busy3), .done_o(done3),
    .underrun_o(ur3), .clr_i(clr), .do_o(do3)
  );

  neopix_tx #(.BYTES_PER_LED(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .start_i(start4), .mode_i(mode),
    .led_count_i(cnt), .pix_ready_o(ready4), .pix_valid_i(valid4),
    .pix_data_i(data4), .addr_o(addr4), .busy_o(busy4), .done_o(done4),
    .underrun_o(ur4), .clr_i(clr), .do_o(do4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  logic sel = 1'b0;
  int rises, first_rise, last_rise, hi_run, xfers, first_xfer, dones, done_cyc, start_cyc;
  int hi_q[$], per_q[$], xaddr_q[$];
  logic prev_do;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    rises = 0; first_rise = 0; last_rise = 0; hi_run = 0; xfers = 0;
    first_xfer = 0; dones = 0; done_cyc = 0; prev_do = 1'b0;
    hi_q.delete(); per_q.delete(); xaddr_q.delete();
  endtask

  task automatic tick();
    logic d, rdy, vld, dn;
    int a;
    @(negedge clk);
    d   = sel ? do4 : do3;
    rdy = sel ? ready4 : ready3;
    vld = sel ? valid4 : valid3;
    dn  = sel ? done4 : done3;
    a   = sel ? int'(addr4) : int'(addr3);
    if (d && !prev_do) begin
      if (rises > 0) per_q.push_back(cyc - last_rise);
      else first_rise = cyc;
      last_rise = cyc;
      rises++;
      hi_run = 1;
    end else if (d) begin
      hi_run++;
    end
    if (!d && prev_do) hi_q.push_back(hi_run);
    if (rdy && vld) begin
      if (xfers == 0) first_xfer = cyc;
      xaddr_q.push_back(a);
      xfers++;
    end
    if (dn) begin
      dones++;
      done_cyc = cyc;
    end
    prev_do = d;
  endtask

  task automatic fire();
    start_cyc = cyc;
    if (sel) start4 = 1'b1; else start3 = 1'b1;
    tick();
    start3 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0, k;
    n0 = dones;
    k = 0;
    while (dones == n0 && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, dones - n0, 1);
    $display("frame %s: done at cycle %0d, rises %0d, transfers %0d", tag, done_cyc, rises, xfers);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k;
    k = 0;
    while (rises < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  function automatic int per_bad();
    int b;
    b = 0;
    foreach (per_q[i]) if (per_q[i] != 62) b++;
    return b;
  endfunction

  initial begin
    int bad, x, r, e;
    logic [31:0] pw, wv;

    pix_tab[0] = 32'h00FF0080; pix_tab[1] = 32'h00123456;
    pix_tab[2] = 32'h00ABCDEF; pix_tab[3] = 32'h00010203;
    pix_tab[4] = 32'h00F0F0F0; pix_tab[5] = 32'h000F0F0F;
    pix_tab[6] = 32'h00AA5500; pix_tab[7] = 32'h0055AA55;
    clr_mon();

    // Reset state
    repeat (3) tick();
    chk("rst_do", do3, 0);
    chk("rst_busy", busy3, 0);
    chk("rst_ready", ready3, 0);
    chk("rst_addr", addr3, 0);
    chk("rst_underrun", ur3, 0);
    chk("rst_done", done3, 0);

    // Power-up: start requested at release must wait out the latch time.
    // Release at cycle x: latch ends x+4000, dispatch, first transfer x+4001, first rise x+4002.
    mode = 1'b0; cnt = 4'd1; src_lim = 4'd8;
    rst = 1'b0;
    x = cyc;
    clr_mon();
    fire();
    repeat (100) tick();
    chk("latch_busy_low", busy3, 0);
    wait_rises(1, 4100);
    chk("pwrup_first_rise", first_rise - x, 4002);
    chk("first_rise_after_xfer", first_rise - first_xfer, 1);
    wait_done("rgb_1px", 6000);
    chk("rgb_rises", rises, 24);
    chk("rgb_hi_count", hi_q.size(), 24);
    for (int i = 0; i < 24; i++) begin
      e = (i < 8) ? 19 : (i < 17) ? 39 : 19;
      chk($sformatf("rgb_hi_%0d", i), (i < hi_q.size()) ? hi_q[i] : -1, e);
    end
    chk("rgb_period_bad", per_bad(), 0);
    chk("rgb_done_latch", done_cyc - (last_rise + 62), 4000);
    chk("rgb_xfers", xfers, 1);
    chk("rgb_addr_hold", addr3, 0);
    chk("rgb_busy_at_done", busy3, 0);

    // SK6812 RGBW, two pixels
    sel = 1'b1; mode = 1'b1; cnt = 4'd2;
    clr_mon();
    fire();
    wait_done("rgbw_2px", 9000);
    mode = 1'b0;
    chk("rgbw_rises", rises, 64);
    chk("rgbw_hi_count", hi_q.size(), 64);
    bad = 0;
    for (int p = 0; p < 2; p++) begin
      pw = (p == 0) ? P4_0 : P4_1;
      wv = {pw[15:8], pw[23:16], pw[7:0], pw[31:24]};
      for (int b = 0; b < 32; b++)
        if (p * 32 + b < hi_q.size() && hi_q[p * 32 + b] != (wv[31 - b] ? 31 : 15)) bad++;
    end
    chk("rgbw_hi_bad", bad, 0);
    chk("rgbw_period_bad", per_bad(), 0);
    chk("rgbw_period_count", per_q.size(), 63);
    chk("rgbw_xfers", xfers, 2);
    chk("rgbw_addr0", (xaddr_q.size() > 0) ? xaddr_q[0] : -1, 0);
    chk("rgbw_addr1", (xaddr_q.size() > 1) ? xaddr_q[1] : -1, 1);

    // Underrun: pixel 2 withheld
    sel = 1'b0; cnt = 4'd3; src_lim = 4'd2;
    clr_mon();
    fire();
    wait_done("underrun_3px", 9000);
    chk("ur_rises", rises, 48);
    chk("ur_flag", ur3, 1);
    chk("ur_done_latch", done_cyc - (last_rise + 62), 4000);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("ur_cleared", ur3, 0);

    // Clear coinciding with the underrun boundary leaves the flag set
    cnt = 4'd2; src_lim = 4'd1;
    clr_mon();
    fire();
    wait_rises(1, 100);
    r = first_rise;
    while (cyc < r + 1487 && cyc < r + 3000) tick();
    chk("ur2_not_early", ur3, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ur2_set_wins", ur3, 1);
    wait_done("underrun_clr", 6000);
    chk("ur2_rises", rises, 24);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    chk("ur2_cleared", ur3, 0);

    // Two start pulses mid-frame -> exactly one more frame
    cnt = 4'd1; src_lim = 4'd8;
    clr_mon();
    fire();
    wait_rises(3, 2000);
    fire();
    repeat (10) tick();
    fire();
    wait_done("pend_a", 6000);
    chk("pend_busy_kept", busy3, 1);
    wait_done("pend_b", 8000);
    repeat (300) tick();
    chk("pend_dones", dones, 2);
    chk("pend_rises", rises, 48);
    chk("pend_busy_idle", busy3, 0);

    // Count 0: edge registered, dispatched, then 4000-cycle flush
    cnt = 4'd0;
    clr_mon();
    fire();
    wait_done("count0", 4100);
    chk("c0_done_cycle", done_cyc - start_cyc, 4002);
    chk("c0_rises", rises, 0);
    chk("c0_xfers", xfers, 0);

    // Count 9 clamps to 8
    cnt = 4'd9;
    clr_mon();
    fire();
    wait_done("count9", 17000);
    chk("c9_rises", rises, 192);
    chk("c9_xfers", xfers, 8);
    bad = 0;
    foreach (xaddr_q[i]) if (xaddr_q[i] != i) bad++;
    chk("c9_addr_seq", bad, 0);
    chk("c9_addr_hold", addr3, 7);
    chk("c9_underrun", ur3, 0);
    chk("c9_period_bad", per_bad(), 0);

    // Reset mid-bit
    cnt = 4'd2;
    clr_mon();
    fire();
    wait_rises(5, 1000);
    chk("mid_pre_do", do3, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_do", do3, 0);
    chk("mid_rst_busy", busy3, 0);
    chk("mid_rst_ready", ready3, 0);
    chk("mid_rst_addr", addr3, 0);
    repeat (3) tick();
    cnt = 4'd1;
    rst = 1'b0;
    x = cyc;
    clr_mon();
    fire();
    wait_rises(1, 4100);
    chk("mid_restart_rise", first_rise - x, 4002);
    wait_done("after_reset", 6000);
    chk("mid_restart_rises", rises, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
